// File: rtl/adxl362_spi_if.sv
// adxl362_spi_if: four-wire SPI bus between the accelerometer controller and its responder
interface adxl362_spi_if;
    logic sclk;
    logic mosi;
    logic ss;
    logic miso;
    modport master (output sclk, output mosi, output ss, input miso);
    modport slave (input sclk, input mosi, input ss, output miso);
endinterface

// File: rtl/adxl362_spi_responder.sv
// adxl362_spi_responder: ADXL362-compatible SPI mode-0 slave answering 0x0A/0x0B from an emulated register file
module adxl362_spi_responder (
    input  logic        clk,
    input  logic        reset,
    adxl362_spi_if.slave spi,
    input  logic [11:0] x_in,
    input  logic [11:0] y_in,
    input  logic [11:0] z_in,
    input  logic [11:0] temp_in,
    input  logic        sample_valid,
    output logic        wr_strobe,
    output logic [5:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic [7:0]  power_ctl
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, WRITE, READ, IGNORE} state_t;

    state_t      state, state_n;
    logic [1:0]  sclk_s, mosi_s, ss_s;
    logic        sclk_d, ss_d;
    logic        sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic [2:0]  bit_cnt;
    logic [6:0]  shreg;
    logic [7:0]  byte_in, addr, tx, rd_addr, rd_val;
    logic        cmd_rd, miso_q;
    logic        byte_done, load, commit, soft_rst, is_smp, wr_ok;
    logic        rd_smp, apply, pend, data_rdy;
    logic [11:0] x_s, y_s, z_s, t_s, x_p, y_p, z_p, t_p;
    logic [7:0]  rw [0:15];

    assign sclk_rise = sclk_s[1] & ~sclk_d;
    assign sclk_fall = ~sclk_s[1] & sclk_d;
    assign ss_rise   = ss_s[1] & ~ss_d;
    assign ss_fall   = ~ss_s[1] & ss_d;
    assign byte_in   = {shreg, mosi_s[1]};
    assign byte_done = sclk_rise && bit_cnt == 3'd7 && (state == CMD || state == ADDR || state == WRITE || state == READ);
    assign load      = byte_done && ((state == ADDR && cmd_rd) || state == READ);
    assign commit    = byte_done && state == WRITE;
    assign soft_rst  = commit && addr == 8'h1F && byte_in == 8'h52;
    assign wr_ok     = addr >= 8'h20 && addr <= 8'h2E;
    assign rd_addr   = (state == ADDR) ? byte_in : addr + 8'd1;
    assign is_smp    = (rd_addr >= 8'h08 && rd_addr <= 8'h0A) || (rd_addr >= 8'h0E && rd_addr <= 8'h15);
    assign spi.miso  = miso_q;
    assign power_ctl = rw[13];

    // Two-flop synchronizers plus one-clk history for edge detection; ss resets low so a held-low ss never looks like a fresh fall
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_s <= 2'b00;
            mosi_s <= 2'b00;
            ss_s   <= 2'b00;
            sclk_d <= 1'b0;
            ss_d   <= 1'b0;
        end else begin
            sclk_s <= {sclk_s[0], spi.sclk};
            mosi_s <= {mosi_s[0], spi.mosi};
            ss_s   <= {ss_s[0], spi.ss};
            sclk_d <= sclk_s[1];
            ss_d   <= ss_s[1];
        end
    end

    // Protocol state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // Next state: command byte picks ADDR or IGNORE, address byte picks READ or WRITE, ss rise always aborts
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = ss_fall ? CMD : IDLE;
            CMD:     state_n = byte_done ? ((byte_in[7:1] == 7'b0000101) ? ADDR : IGNORE) : CMD;
            ADDR:    state_n = byte_done ? (cmd_rd ? READ : WRITE) : ADDR;
            default: state_n = state;
        endcase
        if (ss_rise) state_n = IDLE;
    end

    // Register read mux for the address about to be shifted out
    always_comb begin
        rd_val = 8'h00;
        case (rd_addr)
            8'h00:   rd_val = 8'hAD;
            8'h01:   rd_val = 8'h1D;
            8'h02:   rd_val = 8'hF2;
            8'h03:   rd_val = 8'h01;
            8'h08:   rd_val = x_s[11:4];
            8'h09:   rd_val = y_s[11:4];
            8'h0A:   rd_val = z_s[11:4];
            8'h0B:   rd_val = {7'b0, data_rdy};
            8'h0E:   rd_val = x_s[7:0];
            8'h0F:   rd_val = {{4{x_s[11]}}, x_s[11:8]};
            8'h10:   rd_val = y_s[7:0];
            8'h11:   rd_val = {{4{y_s[11]}}, y_s[11:8]};
            8'h12:   rd_val = z_s[7:0];
            8'h13:   rd_val = {{4{z_s[11]}}, z_s[11:8]};
            8'h14:   rd_val = t_s[7:0];
            8'h15:   rd_val = {{4{t_s[11]}}, t_s[11:8]};
            default: rd_val = (rd_addr >= 8'h20 && rd_addr <= 8'h2E) ? rw[rd_addr[3:0]] : 8'h00;
        endcase
    end

    // Bit counter, input shifter, address pointer, read shifter, miso and write-commit outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt   <= 3'd0;
            shreg     <= 7'd0;
            cmd_rd    <= 1'b0;
            addr      <= 8'h00;
            tx        <= 8'h00;
            miso_q    <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= 6'd0;
            wr_data   <= 8'h00;
        end else begin
            wr_strobe <= commit;
            if (state == IDLE || state == IGNORE || ss_rise) begin
                bit_cnt <= 3'd0;
            end else if (sclk_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
                shreg   <= byte_in[6:0];
            end
            if (byte_done && state == CMD) cmd_rd <= byte_in[0];
            if (byte_done && state == ADDR) addr <= byte_in;
            else if (byte_done && (state == READ || state == WRITE)) addr <= addr + 8'd1;
            if (load) tx <= rd_val;
            if (commit) begin
                wr_addr <= addr[5:0];
                wr_data <= byte_in;
            end
            miso_q <= (state != READ || ss_rise) ? 1'b0 : (sclk_fall ? tx[~bit_cnt] : miso_q);
        end
    end

    // Read/write control registers 0x20-0x2E; soft reset clears them all
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) rw[i] <= 8'h00;
        end else if (soft_rst) begin
            for (int i = 0; i < 16; i++) rw[i] <= 8'h00;
        end else if (commit && wr_ok) begin
            rw[addr[3:0]] <= byte_in;
        end
    end

    // Shadow samples stay frozen while ss is low; updates wait in a pending buffer until after ss rises
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_s      <= 12'd0;
            y_s      <= 12'd0;
            z_s      <= 12'd0;
            t_s      <= 12'd0;
            x_p      <= 12'd0;
            y_p      <= 12'd0;
            z_p      <= 12'd0;
            t_p      <= 12'd0;
            pend     <= 1'b0;
            apply    <= 1'b0;
            rd_smp   <= 1'b0;
            data_rdy <= 1'b0;
        end else begin
            apply <= ss_rise;
            if (load && is_smp) rd_smp <= 1'b1;
            if (ss_rise) begin
                rd_smp <= 1'b0;
                if (rd_smp) data_rdy <= 1'b0;
            end
            if (apply && pend) begin
                x_s      <= x_p;
                y_s      <= y_p;
                z_s      <= z_p;
                t_s      <= t_p;
                pend     <= 1'b0;
                data_rdy <= 1'b1;
            end
            if (sample_valid && ss_s[1]) begin
                x_s      <= x_in;
                y_s      <= y_in;
                z_s      <= z_in;
                t_s      <= temp_in;
                data_rdy <= 1'b1;
            end else if (sample_valid) begin
                x_p  <= x_in;
                y_p  <= y_in;
                z_p  <= z_in;
                t_p  <= temp_in;
                pend <= 1'b1;
            end
            if (soft_rst) data_rdy <= 1'b0;
        end
    end
endmodule

// File: tb/tb_adxl362_spi_responder.sv
// tb_adxl362_spi_responder: directed SPI-master bench for the ADXL362 responder
module tb_adxl362_spi_responder;
    localparam int H = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] x_in = '0, y_in = '0, z_in = '0, temp_in = '0;
    logic        sample_valid = 1'b0;
    logic        wr_strobe;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_data, power_ctl;
    logic [7:0]  r;
    int          checks = 0, failures = 0, strobes = 0, miso_ones = 0, s0, m0;

    adxl362_spi_if spi();

    adxl362_spi_responder dut (
        .clk(clk), .reset(reset), .spi(spi),
        .x_in(x_in), .y_in(y_in), .z_in(z_in), .temp_in(temp_in),
        .sample_valid(sample_valid), .wr_strobe(wr_strobe),
        .wr_addr(wr_addr), .wr_data(wr_data), .power_ctl(power_ctl)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe) strobes++;
        if (spi.miso) miso_ones++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bits(input logic [7:0] d, input int n, output logic [7:0] q);
        q = '0;
        for (int i = 7; i > 7 - n; i--) begin
            spi.mosi = d[i];
            repeat (H) @(negedge clk);
            q[i] = spi.miso;
            spi.sclk = 1'b1;
            repeat (H) @(negedge clk);
            spi.sclk = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] d, output logic [7:0] q);
        bits(d, 8, q);
    endtask

    task automatic ss_lo;
        spi.ss = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic ss_hi;
        repeat (4) @(negedge clk);
        spi.ss = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] j;
        ss_lo;
        xfer(8'h0A, j);
        xfer(a, j);
        xfer(d, j);
        ss_hi;
    endtask

    task automatic rd1(input logic [7:0] a, output logic [7:0] q);
        logic [7:0] j;
        ss_lo;
        xfer(8'h0B, j);
        xfer(a, j);
        xfer(8'h00, q);
        ss_hi;
    endtask

    task automatic pulse(input logic [11:0] x, input logic [11:0] y, input logic [11:0] z, input logic [11:0] t);
        x_in = x;
        y_in = y;
        z_in = z;
        temp_in = t;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [7:0] j;
        spi.ss = 1'b1;
        spi.sclk = 1'b0;
        spi.mosi = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_miso", spi.miso, 0);
        chk("rst_wr_strobe", wr_strobe, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_power_ctl", power_ctl, 0);
        reset = 1'b1;
        repeat (6) @(negedge clk);

        ss_lo;
        xfer(8'h0B, j);
        xfer(8'h00, j);
        xfer(8'h00, r); chk("id0", r, 8'hAD);
        xfer(8'h00, r); chk("id1", r, 8'h1D);
        xfer(8'h00, r); chk("id2", r, 8'hF2);
        xfer(8'h00, r); chk("id3", r, 8'h01);
        ss_hi;

        s0 = strobes;
        wr(8'h2D, 8'h02);
        chk("wr_strobe_n", strobes - s0, 1);
        chk("wr_addr", wr_addr, 6'h2D);
        chk("wr_data", wr_data, 8'h02);
        chk("power_ctl", power_ctl, 8'h02);
        rd1(8'h2D, r); chk("rb_2d", r, 8'h02);

        pulse(12'h123, 12'h000, 12'h000, 12'h000);
        ss_lo;
        xfer(8'h0B, j);
        xfer(8'h0E, j);
        xfer(8'h00, r); chk("coh_lo", r, 8'h23);
        pulse(12'hFED, 12'h000, 12'h000, 12'h000);
        xfer(8'h00, r); chk("coh_hi", r, 8'h01);
        ss_hi;
        ss_lo;
        xfer(8'h0B, j);
        xfer(8'h0E, j);
        xfer(8'h00, r); chk("coh_new_lo", r, 8'hED);
        xfer(8'h00, r); chk("coh_new_hi", r, 8'hFF);
        ss_hi;

        rd1(8'h08, r); chk("x8_fed", r, 8'hFE);
        rd1(8'h0B, r); chk("status_clr", r, 8'h00);
        pulse(12'h5A7, 12'h000, 12'h000, 12'h000);
        rd1(8'h0B, r); chk("status_set", r, 8'h01);
        rd1(8'h08, r); chk("x8_5a7", r, 8'h5A);
        rd1(8'h0B, r); chk("status_clr2", r, 8'h00);

        wr(8'h20, 8'h11);
        pulse(12'h5A7, 12'h000, 12'h000, 12'h000);
        wr(8'h1F, 8'h52);
        chk("srst_power_ctl", power_ctl, 8'h00);
        rd1(8'h20, r); chk("srst_20", r, 8'h00);
        rd1(8'h0B, r); chk("srst_status", r, 8'h00);
        rd1(8'h08, r); chk("srst_keep_x", r, 8'h5A);

        s0 = strobes;
        ss_lo;
        xfer(8'h0A, j);
        xfer(8'h2C, j);
        xfer(8'h77, j);
        xfer(8'h04, j);
        ss_hi;
        chk("burst_strobe_n", strobes - s0, 2);
        chk("burst_wr_addr", wr_addr, 6'h2D);
        chk("burst_power_ctl", power_ctl, 8'h04);
        rd1(8'h2C, r); chk("burst_2c", r, 8'h77);

        s0 = strobes;
        ss_lo;
        xfer(8'h0A, j);
        xfer(8'h2D, j);
        bits(8'h09, 5, j);
        ss_hi;
        chk("abort_strobe_n", strobes - s0, 0);
        chk("abort_power_ctl", power_ctl, 8'h04);

        s0 = strobes;
        wr(8'h60, 8'h55);
        chk("hi_strobe_n", strobes - s0, 1);
        chk("hi_wr_addr", wr_addr, 6'h20);
        rd1(8'h20, r); chk("hi_20_kept", r, 8'h00);

        s0 = strobes;
        wr(8'h00, 8'h99);
        chk("ro_strobe_n", strobes - s0, 1);
        rd1(8'h00, r); chk("ro_id_kept", r, 8'hAD);

        s0 = strobes;
        m0 = miso_ones;
        ss_lo;
        xfer(8'h0D, j);
        xfer(8'hFF, j);
        xfer(8'hFF, j);
        xfer(8'hFF, j);
        ss_hi;
        chk("unk_miso", miso_ones - m0, 0);
        chk("unk_strobe_n", strobes - s0, 0);
        rd1(8'h00, r); chk("unk_then_id", r, 8'hAD);

        s0 = strobes;
        ss_lo;
        xfer(8'h0A, j);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_power_ctl", power_ctl, 8'h00);
        chk("mid_rst_miso", spi.miso, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        xfer(8'h2D, j);
        xfer(8'h07, j);
        ss_hi;
        chk("mid_rst_strobe_n", strobes - s0, 0);
        chk("mid_rst_power_ctl2", power_ctl, 8'h00);
        rd1(8'h00, r); chk("mid_rst_id", r, 8'hAD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
